// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared defaults, controller state encoding and the output
//               shift/saturate helper for the weight-stationary systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  localparam int DEF_N      = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 16;

  // Working width of the output helper; accumulators are sign-extended to this.
  localparam int SAT_W = 64;

  // Controller states, explicitly encoded on two bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Arithmetic right shift (floor) followed by saturation to a signed out_w range.
  function automatic logic signed [SAT_W-1:0] shift_sat(
    input logic signed [SAT_W-1:0] acc,
    input int                      shift,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = acc >>> shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    if (shifted > hi) begin
      shift_sat = hi;
    end else if (shifted < lo) begin
      shift_sat = lo;
    end else begin
      shift_sat = shifted;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pe
// Description : One processing element: stationary weight register, a single
//               multiply-accumulate stage feeding the partial sum downwards,
//               and a registered pass-through of the activation to the right.
//               Everything freezes when en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     w_load,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [ACC_W-1:0]  psum_out
);

  logic signed [DATA_W-1:0]   w_reg;
  logic signed [2*DATA_W-1:0] prod;

  // Full-precision product; both operands are sign-extended before multiplying.
  assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(w_reg);

  // Weight capture, activation hand-off and partial-sum accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg    <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else if (en) begin
      if (w_load) begin
        w_reg <= w_in;
      end
      a_out    <= a_in;
      psum_out <= psum_in + ACC_W'(prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : param_systolic_array
// Description : N x N weight-stationary systolic array computing one
//               vector-matrix product r = sat((a * W) >>> SHIFT) per cycle,
//               with valid/ready handshakes on weights, activations and
//               results. Latency is 2N cycles; the whole pipeline freezes
//               while a result is waiting on r_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module param_systolic_array
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  input  logic [N*DATA_W-1:0]   w_data,
  output logic                  w_ready,
  input  logic                  a_valid,
  input  logic [N*DATA_W-1:0]   a_data,
  output logic                  a_ready,
  output logic                  r_valid,
  output logic [N*OUT_W-1:0]    r_data,
  input  logic                  r_ready,
  output logic                  busy
);

  localparam int ROW_W   = $clog2(N);
  localparam int CNT_W   = $clog2(2*N + 1);
  localparam int VLD_LEN = 2*N - 1;

  state_e             state;
  logic [ROW_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   inflight;
  logic [VLD_LEN-1:0] vld_pipe;
  logic               stall;
  logic               en;
  logic               w_acc;
  logic               a_acc;
  logic               r_acc;

  // a_h[k][j] : activation entering PE(k,j); ps_v[k][j] : partial sum entering PE(k,j).
  logic signed [DATA_W-1:0] a_h     [N][N+1];
  logic signed [ACC_W-1:0]  ps_v    [N+1][N];
  logic signed [ACC_W-1:0]  aligned [N];
  logic [N*OUT_W-1:0]       sat_row;

  // A waiting result freezes every register in the datapath.
  assign stall   = r_valid && !r_ready;
  assign en      = !stall;
  assign busy    = (inflight != '0);
  // Weights only change when nothing is in flight.
  assign w_ready = (state != RUN) || !busy;
  assign w_acc   = w_valid && w_ready;
  // A weight row that can be taken wins, so both never land in one cycle.
  assign a_ready = (state == RUN) && !stall && !w_acc;
  assign a_acc   = a_valid && a_ready;
  assign r_acc   = r_valid && r_ready;

  // Controller: N accepted weight rows move to RUN; any accepted row restarts loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
    end else if (w_acc) begin
      if (row_cnt == ROW_W'(N - 1)) begin
        state   <= RUN;
        row_cnt <= '0;
      end else begin
        state   <= LOAD;
        row_cnt <= row_cnt + ROW_W'(1);
      end
    end
  end

  // In-flight row counter: up on activation accept, down on result accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (a_acc && !r_acc) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!a_acc && r_acc) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  // Valid token travelling alongside each row up to the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[VLD_LEN-2:0], a_acc};
    end
  end

  // Input skew: element k is delayed k cycles so it meets its partial sum in row k.
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic signed [DATA_W-1:0] a_in_k;
    assign a_in_k = a_acc ? $signed(a_data[k*DATA_W +: DATA_W]) : '0;
    if (k == 0) begin : g_direct
      assign a_h[0][0] = a_in_k;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [k];
      // Skew shift register for activation element k.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= a_in_k;
          for (int i = 1; i < k; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_h[k][0] = sr[k-1];
    end
  end

  // PE grid: activations move right, partial sums move down.
  for (genvar k = 0; k < N; k++) begin : g_row
    logic unused_a_tail;
    assign unused_a_tail = ^a_h[k][N];
    for (genvar j = 0; j < N; j++) begin : g_col
      if (k == 0) begin : g_top
        assign ps_v[0][j] = '0;
      end
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .w_load   (w_acc && (row_cnt == ROW_W'(k))),
        .w_in     ($signed(w_data[j*DATA_W +: DATA_W])),
        .a_in     (a_h[k][j]),
        .psum_in  (ps_v[k][j]),
        .a_out    (a_h[k][j+1]),
        .psum_out (ps_v[k+1][j])
      );
    end
  end

  // Output de-skew: column j finishes j cycles after column 0, so pad by N-1-j.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign aligned[j] = ps_v[N][j];
    end else begin : g_delay
      logic signed [ACC_W-1:0] sr [D];
      // De-skew shift register for column j.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= ps_v[N][j];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[j] = sr[D-1];
    end
  end

  // Shift and saturate every aligned column sum.
  always_comb begin
    sat_row = '0;
    for (int j = 0; j < N; j++) begin
      sat_row[j*OUT_W +: OUT_W] = OUT_W'(shift_sat(SAT_W'(aligned[j]), SHIFT, OUT_W));
    end
  end

  // Output register; holds its row while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (en) begin
      r_valid <= vld_pipe[VLD_LEN-1];
      if (vld_pipe[VLD_LEN-1]) begin
        r_data <= sat_row;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_systolic_array
// Description : Self-checking bench for param_systolic_array. Two instances
//               (SHIFT=0 and SHIFT=4) share all inputs; a queue-based model
//               predicts handshakes, timing and results every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_systolic_array;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int OW  = 16;
  localparam int SH1 = 4;

  logic clk = 1'b0;
  logic rst;
  logic w_valid, a_valid, r_ready;
  logic [N*DW-1:0] w_data, a_data;
  logic w_ready0, a_ready0, r_valid0, busy0;
  logic w_ready1, a_ready1, r_valid1, busy1;
  logic [N*OW-1:0] r_data0, r_data1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rr_mode = 0;

  // model state
  longint wm [N][N];
  int mode = 0;  // 0 idle, 1 load, 2 run
  int wrow = 0;
  int age_q[$];
  logic [N*OW-1:0] d0_q[$];
  logic [N*OW-1:0] d1_q[$];

  param_systolic_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready0),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready0), .r_valid(r_valid0),
    .r_data(r_data0), .r_ready(r_ready), .busy(busy0));

  param_systolic_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(SH1)) dut1 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready1),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1), .r_valid(r_valid1),
    .r_data(r_data1), .r_ready(r_ready), .busy(busy1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [N*OW-1:0] act, input logic [N*OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference: plain dot products with the weights held at acceptance time.
  task automatic model_row(input logic [N*DW-1:0] a, output logic [N*OW-1:0] e0,
                           output logic [N*OW-1:0] e1);
    longint s;
    e0 = '0;
    e1 = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += longint'($signed(a[k*DW +: DW])) * wm[k][j];
      e0[j*OW +: OW] = OW'(sat(s));
      e1[j*OW +: OW] = OW'(sat(s >>> SH1));
    end
  endtask

  // Per-cycle compare and model advance, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_rv, exp_wr, exp_ar, stall, w_acc, a_acc, r_acc;
    logic [N*OW-1:0] e0, e1;
    if (rst) begin
      mode = 0;
      wrow = 0;
      for (int k = 0; k < N; k++) for (int j = 0; j < N; j++) wm[k][j] = 0;
      age_q.delete();
      d0_q.delete();
      d1_q.delete();
    end else begin
      exp_rv = (age_q.size() > 0) && (age_q[0] >= 2*N);
      exp_wr = (mode != 2) || (age_q.size() == 0);
      stall  = exp_rv && !r_ready;
      exp_ar = (mode == 2) && !stall;
      chk("r_valid", r_valid0, exp_rv);
      chk("r_valid_sh", r_valid1, exp_rv);
      chk("busy", busy0, age_q.size() > 0);
      chk("busy_sh", busy1, age_q.size() > 0);
      chk("w_ready", w_ready0, exp_wr);
      if (!w_valid) chk("a_ready", a_ready0, exp_ar);
      if (exp_rv) begin
        chkv("r_data", r_data0, d0_q[0]);
        chkv("r_data_sh", r_data1, d1_q[0]);
      end
      w_acc = w_valid && exp_wr;
      a_acc = a_valid && exp_ar && !w_acc;
      r_acc = exp_rv && r_ready;
      if (r_acc) begin
        void'(age_q.pop_front());
        void'(d0_q.pop_front());
        void'(d1_q.pop_front());
      end
      if (!stall) for (int i = 0; i < age_q.size(); i++) age_q[i] = age_q[i] + 1;
      if (a_acc) begin
        model_row(a_data, e0, e1);
        age_q.push_back(1);
        d0_q.push_back(e0);
        d1_q.push_back(e1);
      end
      if (w_acc) begin
        for (int j = 0; j < N; j++) wm[wrow][j] = longint'($signed(w_data[j*DW +: DW]));
        wrow++;
        if (wrow == N) begin
          mode = 2;
          wrow = 0;
        end else begin
          mode = 1;
        end
      end
    end
  end

  // Consumer back-pressure pattern.
  initial begin
    r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: r_ready = 1'b1;
        1: r_ready = ~r_ready;
        2: r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input bit is_w);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = is_w ? w_ready0 : a_ready0;
      if (ok) acc_cyc = cyc;
      n++;
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_handshake: not accepted after %0d cycles, expected accept", is_w ? "w" : "a", n);
    end
  endtask

  task automatic load_rows(input logic [N*N*DW-1:0] m, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      w_valid = 1'b1;
      w_data  = m[k*N*DW +: N*DW];
      wait_acc(1'b1);
    end
    w_valid = 1'b0;
  endtask

  task automatic send_row(input logic [N*DW-1:0] a);
    a_valid = 1'b1;
    a_data  = a;
    wait_acc(1'b0);
    a_valid = 1'b0;
  endtask

  task automatic capture(output logic [N*OW-1:0] d0, output logic [N*OW-1:0] d1, output int lat);
    int n;
    n = 0;
    d0 = '0;
    d1 = '0;
    lat = -1;
    while (lat < 0 && n < 100) begin
      @(negedge clk);
      if (r_valid0) begin
        lat = cyc - acc_cyc;
        d0 = r_data0;
        d1 = r_data1;
      end
      n++;
    end
    tick();
  endtask

  task automatic drain();
    int n;
    rr_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy0 && n < 500);
    chk("drain_busy", busy0, 0);
    tick();
  endtask

  function automatic logic [N*DW-1:0] row_of(input int v [N]);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  function automatic logic [N*N*DW-1:0] ident();
    logic [N*N*DW-1:0] m;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) m[(k*N+j)*DW +: DW] = (k == j) ? DW'(1) : DW'(0);
    return m;
  endfunction

  function automatic logic [N*N*DW-1:0] fill(input int v);
    logic [N*N*DW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*DW +: DW] = DW'(v);
    return m;
  endfunction

  function automatic logic [N*DW-1:0] rand_row(input int span);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(int'($urandom_range(0, 2*span)) - span);
    return r;
  endfunction

  function automatic logic [N*N*DW-1:0] rand_mat(input int span);
    logic [N*N*DW-1:0] m;
    for (int k = 0; k < N; k++) m[k*N*DW +: N*DW] = rand_row(span);
    return m;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*OW-1:0] d0, d1, ev;
    int lat;
    int v [N];
    rst = 1'b1;
    w_valid = 1'b0;
    a_valid = 1'b0;
    w_data = '0;
    a_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_w_ready", w_ready0, 1);
    chk("rst_a_ready", a_ready0, 0);
    chk("rst_r_valid", r_valid0, 0);
    chk("rst_busy", busy0, 0);
    chkv("rst_r_data", r_data0, '0);
    tick();

    // identity weights, a = [1,2,3,4]
    load_rows(ident(), N);
    v = '{1, 2, 3, 4};
    send_row(row_of(v));
    capture(d0, d1, lat);
    chk("ident_latency", lat, 8);
    ev = {16'd4, 16'd3, 16'd2, 16'd1};
    chkv("ident_data", d0, ev);
    chkv("ident_data_sh", d1, '0);

    // arithmetic shift floors: -17 >>> 4 = -2
    v = '{-17, 0, 0, 0};
    send_row(row_of(v));
    capture(d0, d1, lat);
    ev = {48'd0, 16'hFFEF};
    chkv("neg_noshift", d0, ev);
    ev = {48'd0, 16'hFFFE};
    chkv("neg_shift4", d1, ev);
    drain();

    // saturation at both rails
    load_rows(fill(32767), N);
    v = '{32767, 32767, 32767, 32767};
    send_row(row_of(v));
    capture(d0, d1, lat);
    ev = {4{16'h7FFF}};
    chkv("sat_pos", d0, ev);
    chkv("sat_pos_sh", d1, ev);
    v = '{-32768, -32768, -32768, -32768};
    send_row(row_of(v));
    capture(d0, d1, lat);
    ev = {4{16'h8000}};
    chkv("sat_neg", d0, ev);
    chkv("sat_neg_sh", d1, ev);
    drain();

    // back-to-back rows under alternating back-pressure
    load_rows(rand_mat(100), N);
    rr_mode = 1;
    for (int i = 0; i < 12; i++) send_row(rand_row(100));
    drain();

    // full-range random data under random back-pressure
    load_rows(rand_mat(32767), N);
    rr_mode = 2;
    for (int i = 0; i < 16; i++) send_row((i % 2 == 0) ? rand_row(32767) : rand_row(300));
    drain();

    // weight row offered while results are pending
    rr_mode = 3;
    for (int i = 0; i < 3; i++) send_row(rand_row(200));
    w_valid = 1'b1;
    w_data = rand_row(50);
    repeat (12) tick();
    rr_mode = 0;
    load_rows(rand_mat(50), N);
    for (int i = 0; i < 6; i++) send_row(rand_row(1000));
    drain();

    // reset three cycles after two rows were accepted
    send_row(rand_row(500));
    send_row(rand_row(500));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("midrun_rst_busy", busy0, 0);
    chk("midrun_rst_r_valid", r_valid0, 0);
    chk("midrun_rst_w_ready", w_ready0, 1);
    chk("midrun_rst_a_ready", a_ready0, 0);
    tick();

    // reset part-way through a weight load, then a clean reload
    load_rows(rand_mat(9), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_rows(ident(), N);
    v = '{7, -3, 11, -5};
    send_row(row_of(v));
    capture(d0, d1, lat);
    ev = {16'hFFFB, 16'd11, 16'hFFFD, 16'd7};
    chkv("reload_ident", d0, ev);
    rr_mode = 1;
    for (int i = 0; i < 8; i++) send_row(rand_row(32767));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
